dual_wheel_encoder_emulator: RTL and testbench

Generates the quadrature A/B waveforms of two wheel encoders (left, right) from commanded signed step counts and edge periods. It is the transmit side of the dual-wheel odometry path: its outputs drive the `A_left/B_left/A_right/B_right` inputs of the wheel decoder for hardware-in-the-loop tests and bench bring-up without physical motors. Commands are accepted through a valid/ready handshake, and a one-cycle `done` pulse marks completion.

---
 rtl/dual_wheel_encoder_emulator.sv | 217 +++++++++++++++++++++
 tb/tb_dual_wheel_encoder_emulator.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_wheel_encoder_emulator.sv
// dual_wheel_encoder_emulator
// Generates the quadrature A/B waveforms of two wheel encoders from commanded
// signed step counts and per-wheel edge periods. A command is taken on
// cmd_valid & cmd_ready. Each wheel then emits |steps| quadrature edges, one
// every `period` clocks. A one-cycle done pulse marks the end of the command,
// whether it ran to completion or was aborted.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-low reset
//   cmd_valid / cmd_ready    command handshake (ready == idle)
//   cmd_steps_left/right     signed step counts, positive = CW
//   cmd_period_left/right    clocks between edges, clamped up to MIN_PERIOD
//   abort                    stop the running command
//   A_left/B_left            left quadrature outputs
//   A_right/B_right          right quadrature outputs
//   busy, done               status flags; done is a one-cycle pulse
//   pos_left/pos_right       signed edge position counters, present only
//                            with ENCODER_POSITION_EN
//
// Build option: define ENCODER_POSITION_EN to add the position counters.
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for a command, cmd_ready = 1
//   S_RUN  | wheel engines emitting edges
//   S_FIN  | one-cycle done pulse, then back to S_IDLE
module dual_wheel_encoder_emulator #(
  parameter int CNT_W      = 16,
  parameter int DIV_W      = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps_left,
  input  logic [CNT_W-1:0] cmd_steps_right,
  input  logic [DIV_W-1:0] cmd_period_left,
  input  logic [DIV_W-1:0] cmd_period_right,
  input  logic             abort,
  output logic             A_left,
  output logic             B_left,
  output logic             A_right,
  output logic             B_right,
  output logic             busy,
  output logic             done
`ifdef ENCODER_POSITION_EN
  ,
  output logic signed [31:0] pos_left,
  output logic signed [31:0] pos_right
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_PERIOD);
  localparam logic [DIV_W-1:0] ONE_P = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  // Index 0 is the left wheel, index 1 the right wheel.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q [2];
  logic [CNT_W-1:0] rem_d [2];
  logic [DIV_W-1:0] tmr_q [2];
  logic [DIV_W-1:0] tmr_d [2];
  logic [DIV_W-1:0] per_q [2];
  logic [DIV_W-1:0] per_d [2];
  logic             dir_q [2];
  logic             dir_d [2];
  logic [1:0]       ab_q  [2];
  logic [1:0]       ab_d  [2];
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] steps_in [2];
  logic [DIV_W-1:0] per_clamp [2];

`ifdef ENCODER_POSITION_EN
  logic signed [31:0] pos_q [2];
  logic signed [31:0] pos_d [2];
  assign pos_left  = pos_q[0];
  assign pos_right = pos_q[1];
`endif

  assign steps_in[0]  = cmd_steps_left;
  assign steps_in[1]  = cmd_steps_right;
  assign per_clamp[0] = (cmd_period_left  < MIN_P) ? MIN_P : cmd_period_left;
  assign per_clamp[1] = (cmd_period_right < MIN_P) ? MIN_P : cmd_period_right;

  // One quadrature step from the current {A,B}. CW: 00->10->11->01->00,
  // CCW walks the same ring backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic ccw);
    logic [1:0] nxt;
    if (!ccw) begin
      case (ab)
        2'b00:   nxt = 2'b10;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b01;
        default: nxt = 2'b00;
      endcase
    end else begin
      case (ab)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b11;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    per_d   = per_q;
    dir_d   = dir_q;
    ab_d    = ab_q;
`ifdef ENCODER_POSITION_EN
    pos_d   = pos_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_RUN;
          for (int w = 0; w < 2; w++) begin
            dir_d[w] = steps_in[w][CNT_W-1];
            // Two's-complement negate; the most negative value maps to
            // 2^(CNT_W-1), which still fits in the unsigned counter.
            rem_d[w] = steps_in[w][CNT_W-1] ? (~steps_in[w] + ONE_C) : steps_in[w];
            per_d[w] = per_clamp[w];
            tmr_d[w] = per_clamp[w] - ONE_P;
          end
        end
      end
      S_RUN: begin
        for (int w = 0; w < 2; w++) begin
          if (rem_q[w] != '0) begin
            if (tmr_q[w] == '0) begin
              ab_d[w]  = next_phase(ab_q[w], dir_q[w]);
              rem_d[w] = rem_q[w] - ONE_C;
              tmr_d[w] = per_q[w] - ONE_P;
`ifdef ENCODER_POSITION_EN
              pos_d[w] = dir_q[w] ? (pos_q[w] - 32'sd1) : (pos_q[w] + 32'sd1);
`endif
            end else begin
              tmr_d[w] = tmr_q[w] - ONE_P;
            end
          end
        end
        // Abort lets an edge that is due this cycle go out, then empties
        // both counters so the normal both-zero exit fires next cycle and
        // done is pulsed exactly once.
        if (abort) begin
          rem_d[0] = '0;
          rem_d[1] = '0;
        end
        if (rem_q[0] == '0 && rem_q[1] == '0) begin
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int w = 0; w < 2; w++) begin
        rem_q[w] <= '0;
        tmr_q[w] <= '0;
        per_q[w] <= '0;
        dir_q[w] <= 1'b0;
        ab_q[w]  <= 2'b00;
`ifdef ENCODER_POSITION_EN
        pos_q[w] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int w = 0; w < 2; w++) begin
        rem_q[w] <= rem_d[w];
        tmr_q[w] <= tmr_d[w];
        per_q[w] <= per_d[w];
        dir_q[w] <= dir_d[w];
        ab_q[w]  <= ab_d[w];
`ifdef ENCODER_POSITION_EN
        pos_q[w] <= pos_d[w];
`endif
      end
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign A_left    = ab_q[0][1];
  assign B_left    = ab_q[0][0];
  assign A_right   = ab_q[1][1];
  assign B_right   = ab_q[1][0];

endmodule

// File: tb/tb_dual_wheel_encoder_emulator.sv
// Directed bench for dual_wheel_encoder_emulator. Phase is carried from one
// scenario to the next, so each task states the starting levels it expects.
module tb_dual_wheel_encoder_emulator;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps_left;
  logic [15:0] cmd_steps_right;
  logic [15:0] cmd_period_left;
  logic [15:0] cmd_period_right;
  logic        abort;
  logic        A_left, B_left, A_right, B_right;
  logic        busy, done;
`ifdef ENCODER_POSITION_EN
  logic signed [31:0] pos_left, pos_right;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dual_wheel_encoder_emulator dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_steps_left   (cmd_steps_left),
    .cmd_steps_right  (cmd_steps_right),
    .cmd_period_left  (cmd_period_left),
    .cmd_period_right (cmd_period_right),
    .abort            (abort),
    .A_left           (A_left),
    .B_left           (B_left),
    .A_right          (A_right),
    .B_right          (B_right),
    .busy             (busy),
    .done             (done)
`ifdef ENCODER_POSITION_EN
    ,
    .pos_left         (pos_left),
    .pos_right        (pos_right)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one accepting edge (T); returns at T+1ns.
  task automatic start_cmd(input logic [15:0] sl, input logic [15:0] pl,
                           input logic [15:0] sr, input logic [15:0] pr);
    cmd_steps_left   = sl;
    cmd_period_left  = pl;
    cmd_steps_right  = sr;
    cmd_period_right = pr;
    cmd_valid        = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_tests++;
    if ({A_left, B_left, A_right, B_right} !== 4'b0000 || busy !== 1'b0 ||
        cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: ab=%b busy=%b ready=%b done=%b, want ab=0000 busy=0 ready=1 done=0",
               {A_left, B_left, A_right, B_right}, busy, cmd_ready, done);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_cmd(16'd4, 16'd3, 16'd0, 16'd1);
    repeat (3) tick();
    n_tests++;
    if ({A_left, B_left} !== 2'b10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: left=%b busy=%b, want left=10 busy=1", {A_left, B_left}, busy);
    end
    reset = 1'b0;
    #2;
    n_tests++;
    if ({A_left, B_left, A_right, B_right} !== 4'b0000 || busy !== 1'b0 ||
        cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: ab=%b busy=%b ready=%b done=%b, want ab=0000 busy=0 ready=1 done=0",
               {A_left, B_left, A_right, B_right}, busy, cmd_ready, done);
    end
`ifdef ENCODER_POSITION_EN
    n_tests++;
    if (pos_left !== 32'sd0 || pos_right !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_pos: got %0d/%0d want 0/0", pos_left, pos_right);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if (busy !== 1'b0 || {A_left, B_left} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_cmd_lost c=%0d: busy=%b left=%b, want busy=0 left=00", c, busy, {A_left, B_left});
      end
    end
  endtask

  // left +4 @ P3 from 00: 10,11,01,00 at T+3,6,9,12; done at T+13 only.
  task automatic test_left_cw();
    logic [1:0] seq [5];
    logic [1:0] exp_l;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01; seq[4] = 2'b00;
    start_cmd(16'd4, 16'd3, 16'd0, 16'd9);
    n_tests++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL left_cw_accept: busy=%b ready=%b, want 1/0", busy, cmd_ready);
    end
    for (int c = 1; c <= 14; c++) begin
      tick();
      exp_l = seq[(c / 3 > 4) ? 4 : c / 3];
      n_tests++;
      if ({A_left, B_left} !== exp_l || {A_right, B_right} !== 2'b00 || done !== (c == 13)) begin
        n_fail++;
        $display("FAIL left_cw T+%0d: left=%b right=%b done=%b, want left=%b right=00 done=%b",
                 c, {A_left, B_left}, {A_right, B_right}, done, exp_l, (c == 13));
      end
    end
    n_tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL left_cw_idle: busy=%b ready=%b, want 0/1", busy, cmd_ready);
    end
  endtask

  // left +10 @ P2 from 00: 10 at T+2, 11 at T+4; abort sampled at T+5,
  // done at T+6, left holds 11. Then +1 @ P2 gives 01 at T'+2, done T'+3.
  task automatic test_abort_resume();
    logic [1:0] exp_l;
    start_cmd(16'd10, 16'd2, 16'd0, 16'd2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_l = (c < 2) ? 2'b00 : (c < 4) ? 2'b10 : 2'b11;
      n_tests++;
      if ({A_left, B_left} !== exp_l || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_run T+%0d: left=%b done=%b, want left=%b done=0", c, {A_left, B_left}, done, exp_l);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if ({A_left, B_left} !== 2'b11 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_T5: left=%b done=%b busy=%b, want 11/0/1", {A_left, B_left}, done, busy);
    end
    tick();
    n_tests++;
    if ({A_left, B_left} !== 2'b11 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_done: left=%b done=%b, want 11/1", {A_left, B_left}, done);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if ({A_left, B_left} !== 2'b11 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_hold c=%0d: left=%b done=%b busy=%b, want 11/0/0", c, {A_left, B_left}, done, busy);
      end
    end
    start_cmd(16'd1, 16'd2, 16'd0, 16'd2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_l = (c < 2) ? 2'b11 : 2'b01;
      n_tests++;
      if ({A_left, B_left} !== exp_l || done !== (c == 3)) begin
        n_fail++;
        $display("FAIL resume T+%0d: left=%b done=%b, want left=%b done=%b",
                 c, {A_left, B_left}, done, exp_l, (c == 3));
      end
    end
  endtask

  // right -3 @ P5 from 00: 01,11,10 at T+5,10,15; done T+16; left holds 01.
  task automatic test_right_ccw();
    logic [1:0] seq [4];
    logic [1:0] exp_r;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    start_cmd(16'd0, 16'd4, 16'hFFFD, 16'd5);
    for (int c = 1; c <= 17; c++) begin
      tick();
      exp_r = seq[(c / 5 > 3) ? 3 : c / 5];
      n_tests++;
      if ({A_right, B_right} !== exp_r || {A_left, B_left} !== 2'b01 || done !== (c == 16)) begin
        n_fail++;
        $display("FAIL right_ccw T+%0d: right=%b left=%b done=%b, want right=%b left=01 done=%b",
                 c, {A_right, B_right}, {A_left, B_left}, done, exp_r, (c == 16));
      end
    end
`ifdef ENCODER_POSITION_EN
    n_tests++;
    if (pos_left !== 32'sd7 || pos_right !== -32'sd3) begin
      n_fail++;
      $display("FAIL right_ccw_pos: got %0d/%0d want 7/-3", pos_left, pos_right);
    end
`endif
  endtask

  // left +2 @ P0 (clamped to 2) from 01: 00 at T+2, 10 at T+4;
  // right +1 @ P7 from 10: 11 at T+7; done at T+8.
  task automatic test_clamp();
    logic [1:0] exp_l, exp_r;
    start_cmd(16'd2, 16'd0, 16'd1, 16'd7);
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp_l = (c < 2) ? 2'b01 : (c < 4) ? 2'b00 : 2'b10;
      exp_r = (c < 7) ? 2'b10 : 2'b11;
      n_tests++;
      if ({A_left, B_left} !== exp_l || {A_right, B_right} !== exp_r || done !== (c == 8)) begin
        n_fail++;
        $display("FAIL clamp T+%0d: left=%b right=%b done=%b, want left=%b right=%b done=%b",
                 c, {A_left, B_left}, {A_right, B_right}, done, exp_l, exp_r, (c == 8));
      end
    end
`ifdef ENCODER_POSITION_EN
    n_tests++;
    if (pos_left !== 32'sd9 || pos_right !== -32'sd2) begin
      n_fail++;
      $display("FAIL clamp_pos: got %0d/%0d want 9/-2", pos_left, pos_right);
    end
`endif
  endtask

  // cmd_valid while busy is ignored; zero-step command finishes with no edges;
  // a command held valid behind it is taken at T+3.
  task automatic test_handshake();
    int n_done;
    logic [1:0] exp_l;
    start_cmd(16'd1, 16'd4, 16'd0, 16'd4);
    tick();
    cmd_steps_left = 16'd5;
    cmd_valid      = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_done = 0;
    for (int c = 3; c <= 12; c++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done != 1 || {A_left, B_left} !== 2'b11 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: dones=%0d left=%b busy=%b, want 1/11/0", n_done, {A_left, B_left}, busy);
    end
    start_cmd(16'd0, 16'd3, 16'd0, 16'd3);
    cmd_steps_left  = 16'hFFFF;
    cmd_period_left = 16'd2;
    cmd_valid       = 1'b1;
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b, want 1/1", done, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || {A_left, B_left, A_right, B_right} !== 4'b1111) begin
      n_fail++;
      $display("FAIL zero_end: done=%b ready=%b ab=%b, want 0/1/1111",
               done, cmd_ready, {A_left, B_left, A_right, B_right});
    end
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, want 1", busy);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_l = (c < 2) ? 2'b11 : 2'b10;
      n_tests++;
      if ({A_left, B_left} !== exp_l || done !== (c == 3)) begin
        n_fail++;
        $display("FAIL b2b T+%0d: left=%b done=%b, want left=%b done=%b",
                 c, {A_left, B_left}, done, exp_l, (c == 3));
      end
    end
  endtask

  // left +1 @ P3 from 10 with abort sampled on the same edge as the only
  // edge (T+3): 11 still emitted, done once at T+4.
  task automatic test_abort_final_edge();
    int n_done;
    start_cmd(16'd1, 16'd3, 16'd0, 16'd3);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if ({A_left, B_left} !== 2'b11 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_edge_T3: left=%b done=%b, want 11/0", {A_left, B_left}, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_edge_done: done=%b, want 1", done);
    end
    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done != 0 || {A_left, B_left} !== 2'b11 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_edge_after: extra dones=%0d left=%b ready=%b, want 0/11/1",
               n_done, {A_left, B_left}, cmd_ready);
    end
`ifdef ENCODER_POSITION_EN
    n_tests++;
    if (pos_left !== 32'sd10 || pos_right !== -32'sd2) begin
      n_fail++;
      $display("FAIL final_pos: got %0d/%0d want 10/-2", pos_left, pos_right);
    end
`endif
  endtask

  initial begin
    cmd_valid        = 1'b0;
    abort            = 1'b0;
    cmd_steps_left   = '0;
    cmd_steps_right  = '0;
    cmd_period_left  = '0;
    cmd_period_right = '0;
    test_reset();
    test_left_cw();
    test_abort_resume();
    test_right_ccw();
    test_clamp();
    test_handshake();
    test_abort_final_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
